// File: rtl/mem_arbiter_pkg.sv
// Shared types for the four-port line-wide memory arbiter.
package mem_arbiter_pkg;
   typedef logic [31:0]  word;
   typedef logic [127:0] line;
   typedef logic [15:0]  line_be;
   typedef logic [1:0]   mem_arb_idx;

   localparam int MEM_ARB_PORTS = 4;

   typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker for the four memory ports.
// MEM_ARB_PRIO0_EN gives port 0 fixed priority over a 1-3 rotation.
module mem_arb_rr_pick
   import mem_arbiter_pkg::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic       any,
   output logic [1:0] idx
);

   logic [3:0] scan_req;
   mem_arb_idx cand;
   logic       found;

   always_comb begin
      any   = |req;
      idx   = ptr;
      cand  = ptr;
      found = 1'b0;
`ifdef MEM_ARB_PRIO0_EN
      // Port 0 is excluded from the rotation; a pointer of 0 simply starts at 1.
      scan_req = {req[3:1], 1'b0};
`else
      scan_req = req;
`endif
      for (int i = 0; i < MEM_ARB_PORTS; i++) begin
         cand = ptr + mem_arb_idx'(i);
         if (!found && scan_req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
`ifdef MEM_ARB_PRIO0_EN
      if (req[0]) idx = 2'd0;
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Four-master to one-slave Avalon line arbiter, one transaction in flight.
// MEM_ARB_PRIO0_EN: port 0 wins every arbitration; ports 1-3 rotate.
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,

   input  logic [31:0]  in_0_address,
   input  logic         in_0_read,
   input  logic         in_0_write,
   input  logic [127:0] in_0_writedata,
   input  logic [15:0]  in_0_byteenable,
   output logic         in_0_waitrequest,
   output logic [127:0] in_0_readdata,

   input  logic [31:0]  in_1_address,
   input  logic         in_1_read,
   input  logic         in_1_write,
   input  logic [127:0] in_1_writedata,
   input  logic [15:0]  in_1_byteenable,
   output logic         in_1_waitrequest,
   output logic [127:0] in_1_readdata,

   input  logic [31:0]  in_2_address,
   input  logic         in_2_read,
   input  logic         in_2_write,
   input  logic [127:0] in_2_writedata,
   input  logic [15:0]  in_2_byteenable,
   output logic         in_2_waitrequest,
   output logic [127:0] in_2_readdata,

   input  logic [31:0]  in_3_address,
   input  logic         in_3_read,
   input  logic         in_3_write,
   input  logic [127:0] in_3_writedata,
   input  logic [15:0]  in_3_byteenable,
   output logic         in_3_waitrequest,
   output logic [127:0] in_3_readdata,

   input  logic         mem_waitrequest,
   input  logic [127:0] mem_readdata,
   output logic [31:0]  mem_address,
   output logic         mem_read,
   output logic         mem_write,
   output logic [127:0] mem_writedata,
   output logic [15:0]  mem_byteenable
);

   // state    | meaning
   // ARB_IDLE | no grant; picks the next requester for the following cycle
   // ARB_BUSY | granted master is connected straight through to the slave

   arb_state_e state;
   mem_arb_idx grant;
   mem_arb_idx rr_ptr;

   logic [3:0] rd_v;
   logic [3:0] wr_v;
   logic [3:0] req;
   word        addr  [MEM_ARB_PORTS];
   line        wdata [MEM_ARB_PORTS];
   line_be     be    [MEM_ARB_PORTS];
   logic       pick_any;
   mem_arb_idx pick_idx;
   logic [3:0] wait_v;
   line        rdata;

   assign rd_v = {in_3_read, in_2_read, in_1_read, in_0_read};
   assign wr_v = {in_3_write, in_2_write, in_1_write, in_0_write};
   assign req  = rd_v | wr_v;

   assign addr[0]  = in_0_address;
   assign addr[1]  = in_1_address;
   assign addr[2]  = in_2_address;
   assign addr[3]  = in_3_address;
   assign wdata[0] = in_0_writedata;
   assign wdata[1] = in_1_writedata;
   assign wdata[2] = in_2_writedata;
   assign wdata[3] = in_3_writedata;
   assign be[0]    = in_0_byteenable;
   assign be[1]    = in_1_byteenable;
   assign be[2]    = in_2_byteenable;
   assign be[3]    = in_3_byteenable;

   mem_arb_rr_pick u_pick (
      .req (req),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ARB_IDLE;
         grant  <= 2'd0;
         rr_ptr <= 2'd0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_any) begin
                  grant <= pick_idx;
                  state <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               // A dropped request abandons the grant without advancing the pointer.
               if (!req[grant]) begin
                  state <= ARB_IDLE;
               end else if (!mem_waitrequest) begin
                  state <= ARB_IDLE;
`ifdef MEM_ARB_PRIO0_EN
                  if (grant != 2'd0) rr_ptr <= grant + 2'd1;
`else
                  rr_ptr <= grant + 2'd1;
`endif
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      mem_address    = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_writedata  = '0;
      mem_byteenable = '0;
      wait_v         = 4'hF;
      rdata          = '0;
      if (state == ARB_BUSY) begin
         mem_address    = addr[grant];
         mem_read       = rd_v[grant];
         mem_write      = wr_v[grant];
         mem_writedata  = wdata[grant];
         mem_byteenable = be[grant];
         wait_v[grant]  = mem_waitrequest;
         rdata          = mem_readdata;
      end
   end

   assign in_0_waitrequest = wait_v[0];
   assign in_1_waitrequest = wait_v[1];
   assign in_2_waitrequest = wait_v[2];
   assign in_3_waitrequest = wait_v[3];
   assign in_0_readdata    = rdata;
   assign in_1_readdata    = rdata;
   assign in_2_readdata    = rdata;
   assign in_3_readdata    = rdata;

`ifndef SYNTHESIS
   rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(state == ARB_BUSY && mem_read && mem_write))
      else $error("mem_arbiter: granted master drives read and write together");
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: arbitration order, stalls, abort and reset.
module tb_mem_arbiter;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         rd [4];
   logic         wr [4];
   logic [31:0]  ad [4];
   logic [127:0] wd [4];
   logic [15:0]  be [4];
   logic [3:0]   wreq;
   logic [127:0] rdat [4];
   logic         mem_waitrequest;
   logic [127:0] mem_readdata;
   logic [31:0]  mem_address;
   logic         mem_read;
   logic         mem_write;
   logic [127:0] mem_writedata;
   logic [15:0]  mem_byteenable;

   int total = 0;
   int bad   = 0;

   localparam logic [127:0] LINE_A = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;

   always #5 clk = ~clk;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .in_0_address(ad[0]), .in_0_read(rd[0]), .in_0_write(wr[0]),
      .in_0_writedata(wd[0]), .in_0_byteenable(be[0]),
      .in_0_waitrequest(wreq[0]), .in_0_readdata(rdat[0]),
      .in_1_address(ad[1]), .in_1_read(rd[1]), .in_1_write(wr[1]),
      .in_1_writedata(wd[1]), .in_1_byteenable(be[1]),
      .in_1_waitrequest(wreq[1]), .in_1_readdata(rdat[1]),
      .in_2_address(ad[2]), .in_2_read(rd[2]), .in_2_write(wr[2]),
      .in_2_writedata(wd[2]), .in_2_byteenable(be[2]),
      .in_2_waitrequest(wreq[2]), .in_2_readdata(rdat[2]),
      .in_3_address(ad[3]), .in_3_read(rd[3]), .in_3_write(wr[3]),
      .in_3_writedata(wd[3]), .in_3_byteenable(be[3]),
      .in_3_waitrequest(wreq[3]), .in_3_readdata(rdat[3]),
      .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 4; i++) begin
         rd[i] = 1'b0;
         wr[i] = 1'b0;
         ad[i] = 32'h0;
         wd[i] = 128'h0;
         be[i] = 16'h0;
      end
      mem_waitrequest = 1'b0;
      mem_readdata    = 128'h0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      mem_readdata = LINE_A;
      rd[1] = 1'b1;
      ad[1] = 32'hABCD;
      rst_n = 1'b0;
      step();
      step();
      total++;
      if (wreq !== 4'hF) begin bad++; $display("FAIL reset_wait got=%b want=1111", wreq); end
      total++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         bad++; $display("FAIL reset_rw got=%b%b want=00", mem_read, mem_write);
      end
      total++;
      if (mem_address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", mem_address); end
      total++;
      if (rdat[1] !== 128'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdat[1]); end
      clear_inputs();
      rst_n = 1'b1;
   endtask

   task automatic test_stalled_read();
      apply_reset();
      ad[2] = 32'h0000_1040;
      rd[2] = 1'b1;
      be[2] = 16'hFFFF;
      mem_waitrequest = 1'b1;
      #1;
      total++;
      if (mem_read !== 1'b0) begin bad++; $display("FAIL read_arb_cycle got=%b want=0", mem_read); end
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 4) begin
            mem_waitrequest = 1'b0;
            mem_readdata    = LINE_A;
         end
         #1;
         total++;
         if (mem_read !== 1'b1 || mem_address !== 32'h0000_1040) begin
            bad++; $display("FAIL read_busy%0d got rd=%b addr=%h want rd=1 addr=1040", k, mem_read, mem_address);
         end
         total++;
         if (wreq[2] !== (k != 4)) begin
            bad++; $display("FAIL read_wait%0d got=%b want=%b", k, wreq[2], (k != 4));
         end
      end
      total++;
      if (rdat[2] !== LINE_A) begin bad++; $display("FAIL read_data got=%h want=%h", rdat[2], LINE_A); end
      step();
      rd[2] = 1'b0;
      #1;
      total++;
      if (mem_read !== 1'b0) begin bad++; $display("FAIL read_done got=%b want=0", mem_read); end
   endtask

   task automatic test_all_write();
      logic [3:0] expw;
      apply_reset();
      for (int n = 0; n < 4; n++) begin
         wr[n] = 1'b1;
         wd[n] = 128'(n);
         ad[n] = 32'h100 * (n + 1);
      end
      for (int k = 0; k < 8; k++) begin
         if (k > 0) step();
         if (k > 0 && (k % 2) == 0) wr[k/2 - 1] = 1'b0;
         #1;
         if ((k % 2) == 0) begin
            total++;
            if (mem_write !== 1'b0 || wreq !== 4'hF) begin
               bad++; $display("FAIL wr_idle%0d got wr=%b wait=%b want wr=0 wait=1111", k, mem_write, wreq);
            end
         end else begin
            expw = ~(4'b0001 << (k/2));
            total++;
            if (mem_write !== 1'b1 || mem_writedata !== 128'(k/2) || wreq !== expw) begin
               bad++; $display("FAIL wr_busy%0d got wr=%b data=%0h wait=%b want wr=1 data=%0d wait=%b",
                               k, mem_write, mem_writedata, wreq, k/2, expw);
            end
         end
      end
      step();
      wr[3] = 1'b0;
      #1;
      total++;
      if (mem_write !== 1'b0) begin bad++; $display("FAIL wr_end got=%b want=0", mem_write); end
   endtask

   task automatic test_pair(input string name, input int a, input int b, input int exp [4]);
      int got;
      apply_reset();
      rd[a] = 1'b1;
      rd[b] = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         #1;
         got = -1;
         for (int i = 0; i < 4; i++) if (wreq[i] === 1'b0) got = i;
         total++;
         if (got !== exp[c]) begin
            bad++; $display("FAIL %s_c%0d got=%0d want=%0d", name, c, got, exp[c]);
         end
         step();
         #1;
         total++;
         if (mem_read !== 1'b0) begin bad++; $display("FAIL %s_idle%0d got=%b want=0", name, c, mem_read); end
      end
      clear_inputs();
   endtask

   task automatic test_fair_13();
      int exp [4] = '{1, 3, 1, 3};
      test_pair("fair13", 1, 3, exp);
   endtask

   task automatic test_fair_01();
`ifdef MEM_ARB_PRIO0_EN
      int exp [4] = '{0, 0, 0, 0};
`else
      int exp [4] = '{0, 1, 0, 1};
`endif
      test_pair("fair01", 0, 1, exp);
   endtask

   task automatic test_reset_mid_busy();
      apply_reset();
      ad[2] = 32'h2000;
      rd[2] = 1'b1;
      step();
      #1;
      total++;
      if (wreq[2] !== 1'b0) begin bad++; $display("FAIL rmb_pre got=%b want=0", wreq[2]); end
      step();
      rd[2] = 1'b0;
      ad[1] = 32'h3000;
      rd[1] = 1'b1;
      mem_waitrequest = 1'b1;
      step();
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_address !== 32'h3000) begin
         bad++; $display("FAIL rmb_busy got rd=%b addr=%h want rd=1 addr=3000", mem_read, mem_address);
      end
      rst_n = 1'b0;
      ad[0] = 32'h4000;
      rd[0] = 1'b1;
      ad[3] = 32'h5000;
      rd[3] = 1'b1;
      #1;
      total++;
      if (mem_read !== 1'b0 || wreq !== 4'hF || mem_address !== 32'h0) begin
         bad++; $display("FAIL rmb_async got rd=%b wait=%b addr=%h want rd=0 wait=1111 addr=0",
                         mem_read, wreq, mem_address);
      end
      step();
      rst_n = 1'b1;
      mem_waitrequest = 1'b0;
      step();
      #1;
      total++;
      if (mem_address !== 32'h4000 || wreq !== 4'b1110) begin
         bad++; $display("FAIL rmb_regrant got addr=%h wait=%b want addr=4000 wait=1110", mem_address, wreq);
      end
      clear_inputs();
   endtask

   task automatic test_abort();
      apply_reset();
      ad[0] = 32'h6000;
      rd[0] = 1'b1;
      ad[1] = 32'h7000;
      rd[1] = 1'b1;
      mem_waitrequest = 1'b1;
      step();
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_address !== 32'h6000) begin
         bad++; $display("FAIL abort_busy got rd=%b addr=%h want rd=1 addr=6000", mem_read, mem_address);
      end
      step();
      rd[0] = 1'b0;
      #1;
      total++;
      if (mem_read !== 1'b0 || wreq !== 4'hF) begin
         bad++; $display("FAIL abort_drop got rd=%b wait=%b want rd=0 wait=1111", mem_read, wreq);
      end
      step();
      rd[0] = 1'b1;
      #1;
      total++;
      if (mem_read !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b want=0", mem_read); end
      step();
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_address !== 32'h6000) begin
         bad++; $display("FAIL abort_regrant got rd=%b addr=%h want rd=1 addr=6000", mem_read, mem_address);
      end
      clear_inputs();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      test_reset();
      test_stalled_read();
      test_all_write();
      test_fair_13();
      test_reset_mid_busy();
      test_abort();
      test_fair_01();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
